// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
// Runs a req/ack transaction with data memory for loads and stores,
// stalls the upstream pipeline until the access completes or times out,
// and registers the write-back bundle for the WB stage.
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned
// accesses (no request, err_o pulse) instead of clearing address bits [1:0].
module mem_wb_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUResult_i,
    input  logic [31:0] RDData_i,
    input  logic [4:0]  RDaddr_i,
    input  logic        RegWrite_i,
    input  logic        MemToReg_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        stall_o,
    output logic        err_o,
    output logic        RegWrite_o,
    output logic        MemToReg_o,
    output logic [31:0] ALUResult_o,
    output logic [31:0] ReadData_o,
    output logic [4:0]  RDaddr_o
);

    localparam int unsigned CntW = 8;
    localparam logic [CntW-1:0] TimeoutLast = CntW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CntW-1:0] timeoutCnt;
    logic [31:0]     rdataQ;
    logic            timedOut;

    logic memOp;
    logic misaligned;
    logic startAccess;

    assign memOp = MemRead_i | MemWrite_i;

    // Misalignment only matters when the check is built in; otherwise the
    // low address bits are simply dropped when the request is issued.
`ifdef MEM_ALIGN_CHECK_EN
    assign misaligned = memOp & (ALUResult_i[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    // An access starts only from IDLE; in DONE the memory flags still
    // belong to the instruction just served and must not retrigger.
    assign startAccess = (state == IDLE) & memOp & ~misaligned;

    // Freeze upstream while an access is being launched or is in flight.
    assign stall_o = ~rst_i & (startAccess | (state == REQ));

    // FSM, memory request interface and MEM/WB register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            timeoutCnt  <= '0;
            rdataQ      <= '0;
            timedOut    <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            err_o       <= 1'b0;
            RegWrite_o  <= 1'b0;
            MemToReg_o  <= 1'b0;
            ALUResult_o <= '0;
            ReadData_o  <= '0;
            RDaddr_o    <= '0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!memOp) begin
                        RegWrite_o  <= RegWrite_i;
                        MemToReg_o  <= MemToReg_i;
                        ALUResult_o <= ALUResult_i;
                        RDaddr_o    <= RDaddr_i;
                        ReadData_o  <= '0;
                    end else if (misaligned) begin
                        RegWrite_o  <= 1'b0;
                        MemToReg_o  <= 1'b0;
                        ALUResult_o <= ALUResult_i;
                        RDaddr_o    <= RDaddr_i;
                        ReadData_o  <= '0;
                        err_o       <= 1'b1;
                    end else begin
                        // Bubble into WB while the access runs.
                        RegWrite_o  <= 1'b0;
                        MemToReg_o  <= 1'b0;
                        mem_req_o   <= 1'b1;
                        mem_we_o    <= MemWrite_i;
                        mem_addr_o  <= {ALUResult_i[31:2], 2'b00};
                        mem_wdata_o <= RDData_i;
                        timeoutCnt  <= '0;
                        timedOut    <= 1'b0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    RegWrite_o <= 1'b0;
                    MemToReg_o <= 1'b0;
                    if (mem_ack_i) begin
                        rdataQ    <= mem_we_o ? 32'd0 : mem_rdata_i;
                        mem_req_o <= 1'b0;
                        state     <= DONE;
                    end else if (timeoutCnt == TimeoutLast) begin
                        rdataQ    <= '0;
                        mem_req_o <= 1'b0;
                        err_o     <= 1'b1;
                        timedOut  <= 1'b1;
                        state     <= DONE;
                    end else begin
                        timeoutCnt <= timeoutCnt + CntW'(1);
                    end
                end
                DONE: begin
                    // Upstream is still holding the served instruction here.
                    RegWrite_o  <= RegWrite_i & ~timedOut;
                    MemToReg_o  <= MemToReg_i;
                    ALUResult_o <= ALUResult_i;
                    RDaddr_o    <= RDaddr_i;
                    ReadData_o  <= rdataQ;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Testbench for mem_wb_stage: acts as upstream pipeline and data memory,
// checks each instruction against outcomes derived from the stage rules.
module tb_mem_wb_stage;

    localparam int unsigned TO = 4;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUResult_i;
    logic [31:0] RDData_i;
    logic [4:0]  RDaddr_i;
    logic        RegWrite_i;
    logic        MemToReg_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        stall_o;
    logic        err_o;
    logic        RegWrite_o;
    logic        MemToReg_o;
    logic [31:0] ALUResult_o;
    logic [31:0] ReadData_o;
    logic [4:0]  RDaddr_o;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk_i = ~clk_i;

    mem_wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .ALUResult_i (ALUResult_i),
        .RDData_i    (RDData_i),
        .RDaddr_i    (RDaddr_i),
        .RegWrite_i  (RegWrite_i),
        .MemToReg_i  (MemToReg_i),
        .MemRead_i   (MemRead_i),
        .MemWrite_i  (MemWrite_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .stall_o     (stall_o),
        .err_o       (err_o),
        .RegWrite_o  (RegWrite_o),
        .MemToReg_o  (MemToReg_o),
        .ALUResult_o (ALUResult_o),
        .ReadData_o  (ReadData_o),
        .RDaddr_o    (RDaddr_o)
    );

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic stepEdge();
        @(posedge clk_i);
        #1;
    endtask

    task automatic setNop();
        ALUResult_i = '0;
        RDData_i    = '0;
        RDaddr_i    = '0;
        RegWrite_i  = 1'b0;
        MemToReg_i  = 1'b0;
        MemRead_i   = 1'b0;
        MemWrite_i  = 1'b0;
    endtask

    // Present one instruction until the stage accepts it, playing memory
    // (ack after ackAfter request cycles, 0 = never), then check the result.
    task automatic doInstr(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                           input logic rw, input logic m2r, input logic mr, input logic mw,
                           input int ackAfter, input logic [31:0] rdata, input logic stray);
        logic        isMem, misal, timeout, st;
        logic [31:0] wordAddr, expRead;
        int          expReq, expStall, stalls, reqs, errs, cycles;
        logic        done;

        isMem = mr | mw;
        wordAddr = {alu[31:2], 2'b00};
`ifdef MEM_ALIGN_CHECK_EN
        misal = isMem && (alu[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        timeout  = isMem && !misal && (ackAfter == 0 || ackAfter > int'(TO));
        expReq   = (!isMem || misal) ? 0 : (timeout ? int'(TO) : ackAfter);
        expStall = (expReq == 0) ? 0 : 1 + expReq;
        expRead  = (isMem && !misal && !mw && !timeout) ? rdata : 32'd0;

        ALUResult_i = alu;
        RDData_i    = wd;
        RDaddr_i    = rd;
        RegWrite_i  = rw;
        MemToReg_i  = m2r;
        MemRead_i   = mr;
        MemWrite_i  = mw;
        #1;

        stalls = 0; reqs = 0; errs = 0; cycles = 0; done = 1'b0;
        while (!done && cycles < 300) begin
            st = stall_o;
            if (st) stalls++;
            if (cycles > 0 && err_o) errs++;
            if (cycles > 0 && isMem && !misal) checkVal("bubble", 32'(RegWrite_o), 32'd0);
            if (mem_req_o) begin
                reqs++;
                checkVal("addr", mem_addr_o, wordAddr);
                checkVal("we", 32'(mem_we_o), 32'(mw));
                checkVal("wdata", mem_wdata_o, wd);
                if (reqs == ackAfter) begin
                    mem_ack_i   = 1'b1;
                    mem_rdata_i = rdata;
                end
            end else if (!isMem && stray) begin
                mem_ack_i   = 1'b1;
                mem_rdata_i = $urandom;
            end
            stepEdge();
            cycles++;
            mem_ack_i   = 1'b0;
            mem_rdata_i = $urandom;
            if (!st) done = 1'b1;
        end
        if (!done) checkVal("hang", 32'd1, 32'd0);

        checkVal("stalls", 32'(stalls), 32'(expStall));
        checkVal("latency", 32'(cycles), 32'(expStall + 1));
        checkVal("reqCycles", 32'(reqs), 32'(expReq));
        checkVal("timeoutErr", 32'(errs), timeout ? 32'd1 : 32'd0);
        checkVal("RegWrite", 32'(RegWrite_o), 32'(rw && !misal && !timeout));
        checkVal("MemToReg", 32'(MemToReg_o), 32'(m2r && !misal));
        checkVal("ALUResult", ALUResult_o, alu);
        checkVal("RDaddr", 32'(RDaddr_o), 32'(rd));
        checkVal("ReadData", ReadData_o, expRead);
        checkVal("alignErr", 32'(err_o), 32'(misal));
        checkVal("reqIdle", 32'(mem_req_o), 32'd0);
    endtask

    initial begin
        logic [31:0] alu;
        int          kind;

        rst_i       = 1'b1;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        setNop();
        ALUResult_i = 32'hFFFF_FFFF;
        RegWrite_i  = 1'b1;
        stepEdge();
        stepEdge();
        checkVal("rstStall", 32'(stall_o), 32'd0);
        checkVal("rstReq", 32'(mem_req_o), 32'd0);
        checkVal("rstErr", 32'(err_o), 32'd0);
        checkVal("rstRegWrite", 32'(RegWrite_o), 32'd0);
        checkVal("rstALUResult", ALUResult_o, 32'd0);
        checkVal("rstReadData", ReadData_o, 32'd0);
        checkVal("rstAddr", mem_addr_o, 32'd0);
        rst_i = 1'b0;
        setNop();

        // Directed cases
        doInstr(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 0, 32'd0, 1'b0);
        doInstr(32'h40, 32'd0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'hDEADBEEF, 1'b0);
        doInstr(32'h80, 32'hCAFEF00D, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 32'h1111_2222, 1'b0);
        doInstr(32'h44, 32'd0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 0, 32'h3333_4444, 1'b0);
        doInstr(32'h42, 32'd0, 5'd10, 1'b1, 1'b1, 1'b1, 1'b0, 1, 32'h5555_6666, 1'b0);
        doInstr(32'h84, 32'hABCD_0001, 5'd11, 1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h7777_8888, 1'b0);
        doInstr(32'h48, 32'd0, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, int'(TO), 32'h0BAD_F00D, 1'b0);

        // Reset in the middle of an access, then a late ack
        ALUResult_i = 32'h100; RDaddr_i = 5'd3; RegWrite_i = 1'b1;
        MemToReg_i = 1'b1; MemRead_i = 1'b1;
        #1;
        stepEdge();
        stepEdge();
        checkVal("midReqBefore", 32'(mem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        checkVal("midStallRst", 32'(stall_o), 32'd0);
        stepEdge();
        rst_i = 1'b0;
        setNop();
        checkVal("midReq", 32'(mem_req_o), 32'd0);
        checkVal("midWe", 32'(mem_we_o), 32'd0);
        checkVal("midAddr", mem_addr_o, 32'd0);
        checkVal("midRegWrite", 32'(RegWrite_o), 32'd0);
        checkVal("midMemToReg", 32'(MemToReg_o), 32'd0);
        checkVal("midRDaddr", 32'(RDaddr_o), 32'd0);
        checkVal("midALUResult", ALUResult_o, 32'd0);
        mem_ack_i   = 1'b1;
        mem_rdata_i = 32'h5A5A_5A5A;
        #1;
        checkVal("midStallAck", 32'(stall_o), 32'd0);
        stepEdge();
        mem_ack_i = 1'b0;
        checkVal("lateAckReadData", ReadData_o, 32'd0);
        checkVal("lateAckRegWrite", 32'(RegWrite_o), 32'd0);
        checkVal("lateAckReq", 32'(mem_req_o), 32'd0);
        checkVal("lateAckErr", 32'(err_o), 32'd0);

        // Randomized instruction stream, including back-to-back memory ops
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(0, 3));
            alu  = $urandom;
            if ($urandom_range(0, 1) == 0) alu[1:0] = 2'b00;
            doInstr(alu, $urandom, 5'($urandom), 1'($urandom), 1'($urandom),
                    kind == 1 || kind == 3, kind == 2 || kind == 3,
                    int'($urandom_range(0, TO + 2)), $urandom, 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
